// File: rtl/barreira_arbitro.sv
// barreira_arbitro: shares one plate checker between two entry lanes.
// Lanes are granted round-robin. The checker verdict is sampled CHK_LAT cycles
// after the plate is driven. Each lane's barrier then opens for OPEN_CYCLES, or
// closes early when a car passes.
// Optional accept/reject statistics are built when BARREIRA_STATS_EN is defined.
module barreira_arbitro #(
    parameter int CHK_LAT     = 2,  // 1..15
    parameter int OPEN_CYCLES = 8   // 1..255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  Dia,
    input  logic        Req0,
    input  logic [23:0] Plate0,
    input  logic        Req1,
    input  logic [23:0] Plate1,
    input  logic        CarPassed0,
    input  logic        CarPassed1,
    output logic [23:0] ChkPlate,
    output logic [2:0]  ChkDia,
    input  logic        ChkMatrVal,
    input  logic        ChkBarreira,
    output logic        Ack0,
    output logic        Ack1,
    output logic        Reject0,
    output logic        Reject1,
    output logic        Barrier0,
    output logic        Barrier1,
    output logic        Busy,
    output logic [7:0]  CntOk,
    output logic [7:0]  CntRej
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_next;
    logic [1:0]  req, car, armed, eligible, barrier, ack, rej;
    logic [7:0]  tmr [2];
    logic [3:0]  lat_cnt;
    logic        ptr;        // lane favoured when both lanes are eligible
    logic        cur_lane;   // lane owning the current checker transaction
    logic        grant, grant_lane, done, accept;

    assign req      = {Req1, Req0};
    assign car      = {CarPassed1, CarPassed0};
    // A lane with an open barrier or an already-serviced request waits.
    assign eligible = req & armed & ~barrier;
    assign accept   = ChkMatrVal & ChkBarreira;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: grant in IDLE, detect the checker sampling edge in WAIT.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        done       = 1'b0;
        grant_lane = (eligible[0] && eligible[1]) ? ptr : eligible[1];
        case (state)
            IDLE: if (|eligible) begin
                grant      = 1'b1;
                state_next = WAIT;
            end
            WAIT: if (lat_cnt == 4'd1) begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Transaction registers: checker drive, latency counter, owner lane, pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ChkPlate <= '0;
            ChkDia   <= '0;
            lat_cnt  <= '0;
            cur_lane <= 1'b0;
            Busy     <= 1'b0;
            ptr      <= 1'b0;
        end else if (grant) begin
            ChkPlate <= grant_lane ? Plate1 : Plate0;
            ChkDia   <= Dia;
            lat_cnt  <= 4'(CHK_LAT);
            cur_lane <= grant_lane;
            Busy     <= 1'b1;
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 4'd1;
            if (done) begin
                Busy <= 1'b0;
                ptr  <= ~cur_lane;
            end
        end
    end

    // One-cycle Ack/Reject pulses on the sampling edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ack <= '0;
            rej <= '0;
        end else begin
            ack <= '0;
            rej <= '0;
            if (done) begin
                ack[cur_lane] <= 1'b1;
                rej[cur_lane] <= ~accept;
            end
        end
    end

    // Armed flags: cleared by the lane's Ack, re-armed once its Req is seen low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (done && cur_lane == i[0]) armed[i] <= 1'b0;
                else if (!req[i])             armed[i] <= 1'b1;
            end
        end
    end

    // Barrier and hold timer per lane; a car passing closes the barrier early.
    // NOTE: the two-entry timer array is reset explicitly, because an open barrier depends on it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            barrier <= '0;
            tmr[0]  <= '0;
            tmr[1]  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (done && cur_lane == i[0] && accept) begin
                    barrier[i] <= 1'b1;
                    tmr[i]     <= 8'(OPEN_CYCLES);
                end else if (barrier[i]) begin
                    if (car[i] || tmr[i] == 8'd1) begin
                        barrier[i] <= 1'b0;
                        tmr[i]     <= '0;
                    end else begin
                        tmr[i] <= tmr[i] - 8'd1;
                    end
                end
            end
        end
    end

    assign Ack0     = ack[0];
    assign Ack1     = ack[1];
    assign Reject0  = rej[0];
    assign Reject1  = rej[1];
    assign Barrier0 = barrier[0];
    assign Barrier1 = barrier[1];

`ifdef BARREIRA_STATS_EN
    // Saturating accept and reject counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CntOk  <= '0;
            CntRej <= '0;
        end else if (done) begin
            if (accept && CntOk != 8'hFF)   CntOk  <= CntOk + 8'd1;
            if (!accept && CntRej != 8'hFF) CntRej <= CntRej + 8'd1;
        end
    end
`else
    assign CntOk  = '0;
    assign CntRej = '0;
`endif

endmodule
